// File: rtl/axil_scratch_pkg.sv
// rtl/axil_scratch_pkg.sv - shared response codes and FSM state types for the scratch memory slave
package axil_scratch_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    WR_IDLE = 1'b0,
    WR_RESP = 1'b1
  } wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_DATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/axil_scratch_ram.sv
// rtl/axil_scratch_ram.sv - simple dual-port word RAM, byte-enabled write, registered read-first read
module axil_scratch_ram #(
  parameter int DEPTH  = 768,
  parameter int IDX_W  = 10,
  parameter int DATA_W = 32
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [IDX_W-1:0]      i_waddr,
  input  logic [DATA_W/8-1:0]   i_wbe,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic                  i_re,
  input  logic [IDX_W-1:0]      i_raddr,
  output logic [DATA_W-1:0]     o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_q;

  // Byte-masked write and registered read; a same-word read sees the pre-write contents
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < DATA_W/8; b++) begin
        if (i_wbe[b]) begin
          r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
    if (i_re) begin
      r_q <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/axil_scratch_mem_slave.sv
// rtl/axil_scratch_mem_slave.sv - AXI4-Lite slave over an on-chip word RAM with out-of-range SLVERR
module axil_scratch_mem_slave
  import axil_scratch_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 768
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [ADDR_W-1:0]     awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready,
  input  logic [ADDR_W-1:0]     araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [IDX_W:0] DEPTH_L = DEPTH[IDX_W:0];

  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx);
    return ({1'b0, idx} < DEPTH_L);
  endfunction

  // Byte-offset address bits carry no meaning for word accesses
  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, awaddr[1:0], araddr[1:0]};

  // ---------------- write path ----------------
  wr_state_e             r_wr_state, w_wr_next;
  logic                  r_awready, r_wready, r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_aw_done, r_w_done, r_aw_ok;
  logic [IDX_W-1:0]      r_aw_idx;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W/8-1:0]   r_wstrb;
  logic                  w_aw_hs, w_w_hs, w_b_hs, w_wr_commit;

  assign w_aw_hs     = awvalid & r_awready;
  assign w_w_hs      = wvalid & r_wready;
  assign w_b_hs      = r_bvalid & bready;
  assign w_wr_commit = (r_wr_state == WR_IDLE) & r_aw_done & r_w_done;

  // Write FSM state register
  always_ff @(posedge aclk) begin
    if (areset) r_wr_state <= WR_IDLE;
    else        r_wr_state <= w_wr_next;
  end

  // Write FSM next state: commit once both halves are latched, wait out the B handshake
  always_comb begin
    w_wr_next = r_wr_state;
    case (r_wr_state)
      WR_IDLE: if (w_wr_commit) w_wr_next = WR_RESP;
      WR_RESP: if (w_b_hs)      w_wr_next = WR_IDLE;
      default: w_wr_next = WR_IDLE;
    endcase
  end

  // AW/W latches, registered readies and the B channel
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_aw_ok   <= 1'b0;
      r_aw_idx  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else if (r_wr_state == WR_IDLE) begin
      if (w_wr_commit) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= r_aw_ok ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (w_aw_hs) begin
          r_aw_done <= 1'b1;
          r_aw_idx  <= awaddr[ADDR_W-1:2];
          r_aw_ok   <= idx_in_range(awaddr[ADDR_W-1:2]);
          r_awready <= 1'b0;
        end else begin
          r_awready <= ~r_aw_done;
        end
        if (w_w_hs) begin
          r_w_done  <= 1'b1;
          r_wdata   <= wdata;
          r_wstrb   <= wstrb;
          r_wready  <= 1'b0;
        end else begin
          r_wready  <= ~r_w_done;
        end
      end
    end else if (w_b_hs) begin
      r_bvalid  <= 1'b0;
      r_awready <= 1'b1;
      r_wready  <= 1'b1;
    end
  end

  // ---------------- read path ----------------
  rd_state_e             r_rd_state, w_rd_next;
  logic                  r_arready, r_rvalid, r_ar_pend, r_ar_ok, r_rd_ok;
  logic [1:0]            r_rresp;
  logic [IDX_W-1:0]      r_ar_idx;
  logic                  w_ar_hs, w_r_hs, w_rd_fire;
  logic [DATA_W-1:0]     w_ram_q;

  assign w_ar_hs   = arvalid & r_arready;
  assign w_r_hs    = r_rvalid & rready;
  assign w_rd_fire = (r_rd_state == RD_IDLE) & r_ar_pend;

  // Read FSM state register
  always_ff @(posedge aclk) begin
    if (areset) r_rd_state <= RD_IDLE;
    else        r_rd_state <= w_rd_next;
  end

  // Read FSM next state: present data the edge after AR, hold until rready
  always_comb begin
    w_rd_next = r_rd_state;
    case (r_rd_state)
      RD_IDLE: if (w_rd_fire) w_rd_next = RD_DATA;
      RD_DATA: if (w_r_hs)    w_rd_next = RD_IDLE;
      default: w_rd_next = RD_IDLE;
    endcase
  end

  // AR latch, registered arready and the R channel flags
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_ar_pend <= 1'b0;
      r_ar_ok   <= 1'b0;
      r_ar_idx  <= '0;
      r_rd_ok   <= 1'b0;
    end else if (r_rd_state == RD_IDLE) begin
      if (w_rd_fire) begin
        r_ar_pend <= 1'b0;
        r_rvalid  <= 1'b1;
        r_rresp   <= r_ar_ok ? RESP_OKAY : RESP_SLVERR;
        r_rd_ok   <= r_ar_ok;
      end else if (w_ar_hs) begin
        r_ar_pend <= 1'b1;
        r_ar_idx  <= araddr[ADDR_W-1:2];
        r_ar_ok   <= idx_in_range(araddr[ADDR_W-1:2]);
        r_arready <= 1'b0;
      end else begin
        r_arready <= 1'b1;
      end
    end else if (w_r_hs) begin
      r_rvalid  <= 1'b0;
      r_arready <= 1'b1;
    end
  end

  // The RAM output register is the read-data register; out-of-range and reset force zero
  axil_scratch_ram #(
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .i_clk   (aclk),
    .i_we    (w_wr_commit & r_aw_ok & ~areset),
    .i_waddr (r_aw_idx),
    .i_wbe   (r_wstrb),
    .i_wdata (r_wdata),
    .i_re    (w_rd_fire & r_ar_ok & ~areset),
    .i_raddr (r_ar_idx),
    .o_rdata (w_ram_q)
  );

  assign awready = r_awready;
  assign wready  = r_wready;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;
  assign arready = r_arready;
  assign rvalid  = r_rvalid;
  assign rresp   = r_rresp;
  assign rdata   = r_rd_ok ? w_ram_q : '0;

endmodule

// File: tb/tb_axil_scratch_mem_slave.sv
// tb/tb_axil_scratch_mem_slave.sv - self-checking bench for axil_scratch_mem_slave
module tb_axil_scratch_mem_slave;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [11:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [11:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  axil_scratch_mem_slave dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  // Reference memory: a plain word array plus a flag for words whose every byte is known
  logic [31:0] m_mem [1024];
  bit          m_known [1024];

  function automatic bit m_in_range(input logic [11:0] a);
    return int'(a[11:2]) < 768;
  endfunction

  function automatic void m_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx = int'(a[11:2]);
    if (idx < 768) begin
      for (int b = 0; b < 4; b++) if (s[b]) m_mem[idx][8*b +: 8] = d[8*b +: 8];
      if (s == 4'hF) m_known[idx] = 1'b1;
    end
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    return m_in_range(a) ? m_mem[int'(a[11:2])] : 32'h0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, output logic [1:0] resp);
    bit aw_pend = 1'b1;
    bit w_pend  = 1'b1;
    bit awh, wh;
    int c = 0;
    int lat = 0;
    awaddr = a; wdata = d; wstrb = s; bready = 1'b0;
    while ((aw_pend || w_pend) && c < 40) begin
      awvalid = aw_pend && (c >= aw_dly);
      wvalid  = w_pend && (c >= w_dly);
      awh = awvalid && awready;
      wh  = wvalid && wready;
      step();
      c++;
      if (awh) begin aw_pend = 1'b0; awvalid = 1'b0; chk("awready_drop", 32'(awready), 32'd0); end
      if (wh)  begin w_pend = 1'b0;  wvalid = 1'b0;  chk("wready_drop", 32'(wready), 32'd0); end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_hs_timeout", 32'({aw_pend, w_pend}), 32'd0);
    while (!bvalid && lat < 20) begin step(); lat++; end
    chk("b_latency", 32'(lat), 32'd1);
    resp = bresp;
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("bvalid_clear", 32'(bvalid), 32'd0);
    chk("wr_readies_back", 32'({awready, wready}), 32'd3);
  endtask

  task automatic do_read(input logic [11:0] a, input int ar_dly,
                         output logic [1:0] resp, output logic [31:0] data);
    bit pend = 1'b1;
    bit arh;
    int c = 0;
    int lat = 0;
    araddr = a; rready = 1'b0;
    while (pend && c < 40) begin
      arvalid = (c >= ar_dly);
      arh = arvalid && arready;
      step();
      c++;
      if (arh) begin pend = 1'b0; arvalid = 1'b0; chk("arready_drop", 32'(arready), 32'd0); end
    end
    arvalid = 1'b0;
    chk("rd_hs_timeout", 32'(pend), 32'd0);
    while (!rvalid && lat < 20) begin step(); lat++; end
    chk("r_latency", 32'(lat), 32'd1);
    resp = rresp; data = rdata;
    rready = 1'b1;
    step();
    rready = 1'b0;
    chk("rvalid_clear", 32'(rvalid), 32'd0);
    chk("arready_back", 32'(arready), 32'd1);
  endtask

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [15];

  initial begin
    logic [1:0]  resp;
    logic [31:0] data, held;
    logic [1:0]  held_resp;

    vecs[0]  = '{1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 0, 2'b00, 32'h0};
    vecs[1]  = '{1'b0, 12'h010, 32'h0,        4'h0, 0, 0, 2'b00, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 12'h020, 32'hCAFEF00D, 4'hF, 3, 0, 2'b00, 32'h0};
    vecs[3]  = '{1'b0, 12'h020, 32'h0,        4'h0, 1, 0, 2'b00, 32'hCAFEF00D};
    vecs[4]  = '{1'b1, 12'h010, 32'h11223344, 4'b0101, 0, 0, 2'b00, 32'h0};
    vecs[5]  = '{1'b0, 12'h010, 32'h0,        4'h0, 0, 0, 2'b00, 32'hDE22BE44};
    vecs[6]  = '{1'b1, 12'hC00, 32'hFFFFFFFF, 4'hF, 0, 0, 2'b10, 32'h0};
    vecs[7]  = '{1'b0, 12'hC00, 32'h0,        4'h0, 0, 0, 2'b10, 32'h0};
    vecs[8]  = '{1'b1, 12'h010, 32'h00000000, 4'h0, 0, 1, 2'b00, 32'h0};
    vecs[9]  = '{1'b0, 12'h010, 32'h0,        4'h0, 2, 0, 2'b00, 32'hDE22BE44};
    vecs[10] = '{1'b1, 12'hBFC, 32'h12345678, 4'hF, 0, 0, 2'b00, 32'h0};
    vecs[11] = '{1'b0, 12'hBFC, 32'h0,        4'h0, 0, 0, 2'b00, 32'h12345678};
    vecs[12] = '{1'b0, 12'hFFC, 32'h0,        4'h0, 0, 0, 2'b10, 32'h0};
    vecs[13] = '{1'b1, 12'h004, 32'hA5A5A5A5, 4'hF, 0, 2, 2'b00, 32'h0};
    vecs[14] = '{1'b0, 12'h004, 32'h0,        4'h0, 0, 0, 2'b00, 32'hA5A5A5A5};

    // Reset state
    repeat (3) step();
    chk("rst_readies", 32'({awready, wready, arready}), 32'd0);
    chk("rst_valids", 32'({bvalid, rvalid}), 32'd0);
    chk("rst_resps", 32'({bresp, rresp}), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    areset = 1'b0;
    step();
    chk("post_rst_readies", 32'({awready, wready, arready}), 32'd7);

    // Directed vectors
    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].aw_dly, vecs[i].w_dly, resp);
        m_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
        chk($sformatf("vec%0d_bresp", i), 32'(resp), 32'(vecs[i].exp_resp));
      end else begin
        do_read(vecs[i].addr, vecs[i].aw_dly, resp, data);
        chk($sformatf("vec%0d_rresp", i), 32'(resp), 32'(vecs[i].exp_resp));
        chk($sformatf("vec%0d_rdata", i), data, vecs[i].exp_rdata);
      end
    end

    // B stalled for 5 cycles with a second AW waiting
    awaddr = 12'h030; wdata = 32'h0BADF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    step();
    chk("stall_bvalid_rise", 32'(bvalid), 32'd1);
    held_resp = bresp;
    chk("stall_bresp", 32'(held_resp), 32'd0);
    m_write(12'h030, 32'h0BADF00D, 4'hF);
    awaddr = 12'h034; awvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_bvalid_hold", 32'({bvalid, bresp}), 32'({1'b1, held_resp}));
      chk("stall_aw_blocked", 32'(awready), 32'd0);
    end
    bready = 1'b1;
    step();
    bready = 1'b0;
    chk("stall_b_done", 32'(bvalid), 32'd0);
    chk("stall_aw_ready_after_b", 32'(awready), 32'd1);
    step();
    awvalid = 1'b0;
    chk("stall_aw_taken", 32'(awready), 32'd0);
    wdata = 32'h5EEDC0DE; wvalid = 1'b1;
    step();
    wvalid = 1'b0;
    step();
    chk("stall_second_b", 32'({bvalid, bresp}), 32'({1'b1, 2'b00}));
    bready = 1'b1;
    step();
    bready = 1'b0;
    m_write(12'h034, 32'h5EEDC0DE, 4'hF);
    do_read(12'h034, 0, resp, data);
    chk("stall_second_rdata", data, 32'h5EEDC0DE);

    // Reset while R is pending
    araddr = 12'h010; arvalid = 1'b1;
    step();
    arvalid = 1'b0;
    step();
    chk("rst_mid_rvalid_before", 32'(rvalid), 32'd1);
    areset = 1'b1;
    step();
    chk("rst_mid_rvalid_cleared", 32'(rvalid), 32'd0);
    step();
    areset = 1'b0;
    step();
    chk("rst_mid_arready_back", 32'(arready), 32'd1);
    do_read(12'h010, 0, resp, data);
    chk("rst_mid_rdata_kept", data, m_read(12'h010));

    // Randomized traffic against the reference memory
    for (int n = 0; n < 80; n++) begin
      logic [11:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      int idx;
      idx = ($urandom_range(0, 4) == 0) ? int'($urandom_range(768, 1023)) : int'($urandom_range(0, 767));
      a = 12'(idx << 2);
      if ($urandom_range(0, 1) == 1 || (idx < 768 && !m_known[idx])) begin
        d = $urandom;
        s = (idx < 768 && !m_known[idx]) ? 4'hF : 4'($urandom_range(0, 15));
        do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), resp);
        m_write(a, d, s);
        chk("rnd_bresp", 32'(resp), m_in_range(a) ? 32'd0 : 32'd2);
      end else begin
        do_read(a, $urandom_range(0, 3), resp, data);
        chk("rnd_rresp", 32'(resp), m_in_range(a) ? 32'd0 : 32'd2);
        chk("rnd_rdata", data, m_read(a));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
